// File: rtl/audio_wr_pack_fifo.sv
// Packs pairs of audio samples into DDR words (first sample in the low half) and
// buffers them in a first-word-fall-through FIFO for the DDR3 AXI write master.
module audio_wr_pack_fifo #(
    parameter int AUDIO_WIDTH = 16,
    parameter int DQ_WIDTH    = 32,
    parameter int FIFO_DEPTH  = 256,
    parameter int LEVEL_WIDTH = 9
) (
    input  logic                   M_AXI_ACLK,
    input  logic                   M_AXI_ARESET,
    input  logic                   DDR_INIT_DONE,
    input  logic                   audio_in_valid,
    input  logic [AUDIO_WIDTH-1:0] audio_in_data,
    input  logic                   wfifo_rd_req,
    output logic [DQ_WIDTH-1:0]    wfifo_rd_data,
    output logic [LEVEL_WIDTH-1:0] wfifo_rd_water_level,
    output logic                   pack_half,
    output logic                   ovf_sticky,
    output logic                   udf_sticky,
    input  logic                   sticky_clr
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [LEVEL_WIDTH-1:0] FULL_LEVEL = LEVEL_WIDTH'(FIFO_DEPTH);

    typedef enum logic {
        PACK_LOW  = 1'b0,
        PACK_HIGH = 1'b1
    } pack_state_e;

    pack_state_e            state_q, state_d;
    logic [AUDIO_WIDTH-1:0] hold_q, hold_d;
    logic                   push_q, push_d;
    logic [DQ_WIDTH-1:0]    push_word_q, push_word_d;

    logic [LEVEL_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
    logic [LEVEL_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
    logic [LEVEL_WIDTH-1:0] level;
    logic                   ovf_q, ovf_d;
    logic                   udf_q, udf_d;

    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   do_pop;
    logic                   do_push;
    logic                   ovf_set;
    logic                   udf_set;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;

    logic [DQ_WIDTH-1:0]    mem_q [FIFO_DEPTH];

    // Packer: a completed pair is registered into push_q and written one cycle later.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        push_d      = 1'b0;
        push_word_d = push_word_q;
        if (!DDR_INIT_DONE) begin
            state_d = PACK_LOW;
            hold_d  = '0;
        end else if (audio_in_valid) begin
            case (state_q)
                PACK_LOW: begin
                    hold_d  = audio_in_data;
                    state_d = PACK_HIGH;
                end
                PACK_HIGH: begin
                    push_d      = 1'b1;
                    push_word_d = {audio_in_data, hold_q};
                    hold_d      = '0;
                    state_d     = PACK_LOW;
                end
                default: state_d = PACK_LOW;
            endcase
        end
    end

    assign level      = wr_cnt_q - rd_cnt_q;
    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == FULL_LEVEL);
    assign wr_ptr     = wr_cnt_q[PTR_W-1:0];
    assign rd_ptr     = rd_cnt_q[PTR_W-1:0];

    // A push into a full FIFO still lands when the head is popped in the same cycle.
    always_comb begin
        do_pop   = wfifo_rd_req && !fifo_empty;
        do_push  = push_q && (!fifo_full || do_pop);
        ovf_set  = push_q && fifo_full && !do_pop;
        udf_set  = wfifo_rd_req && fifo_empty;
        wr_cnt_d = wr_cnt_q + LEVEL_WIDTH'(do_push);
        rd_cnt_d = rd_cnt_q + LEVEL_WIDTH'(do_pop);
        ovf_d    = ovf_set ? 1'b1 : (sticky_clr ? 1'b0 : ovf_q);
        udf_d    = udf_set ? 1'b1 : (sticky_clr ? 1'b0 : udf_q);
    end

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            state_q     <= PACK_LOW;
            hold_q      <= '0;
            push_q      <= 1'b0;
            push_word_q <= '0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            push_q      <= push_d;
            push_word_q <= push_word_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
        end
    end

    // Storage is not reset; stale entries are unreachable once the counters clear.
    always_ff @(posedge M_AXI_ACLK) begin
        if (do_push) begin
            mem_q[wr_ptr] <= push_word_q;
        end
    end

    assign wfifo_rd_data        = fifo_empty ? '0 : mem_q[rd_ptr];
    assign wfifo_rd_water_level = level;
    assign pack_half            = (state_q == PACK_HIGH);
    assign ovf_sticky           = ovf_q;
    assign udf_sticky           = udf_q;

endmodule

// File: tb/tb_audio_wr_pack_fifo.sv
// Bench for audio_wr_pack_fifo: directed scenarios plus randomized streaming,
// checked against a sample-stream / word-queue reference model.
module tb_audio_wr_pack_fifo;
  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int DEPTH = 256;
  localparam int LW    = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          init;
  logic          in_valid;
  logic [AW-1:0] in_data;
  logic          rd_req;
  logic          clr;
  logic [DW-1:0] rd_data;
  logic [LW-1:0] level;
  logic          pack_half;
  logic          ovf;
  logic          udf;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [DW-1:0] exp_q[$];
  bit            m_half;
  logic [AW-1:0] m_hold;
  bit            m_pend;
  logic [DW-1:0] m_pend_w;
  bit            m_ovf;
  bit            m_udf;

  always #5 clk = ~clk;

  audio_wr_pack_fifo dut (
    .M_AXI_ACLK           (clk),
    .M_AXI_ARESET         (rst),
    .DDR_INIT_DONE        (init),
    .audio_in_valid       (in_valid),
    .audio_in_data        (in_data),
    .wfifo_rd_req         (rd_req),
    .wfifo_rd_data        (rd_data),
    .wfifo_rd_water_level (level),
    .pack_half            (pack_half),
    .ovf_sticky           (ovf),
    .udf_sticky           (udf),
    .sticky_clr           (clr)
  );

  function automatic logic [LW-1:0] exp_level();
    return LW'(exp_q.size());
  endfunction

  function automatic logic [DW-1:0] exp_head();
    return (exp_q.size() > 0) ? exp_q[0] : '0;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_half = 0; m_hold = '0; m_pend = 0; m_pend_w = '0; m_ovf = 0; m_udf = 0;
  endtask

  // One clock edge of the reference: the word completed last edge becomes
  // readable now; a completed pair becomes readable one edge later.
  task automatic model_edge(input bit v, input logic [AW-1:0] d, input bit rq,
                            input bit cl, input bit en);
    bit popped, ovf_ev, udf_ev, was_full;
    was_full = (exp_q.size() == DEPTH);
    popped   = rq && (exp_q.size() > 0);
    udf_ev   = rq && (exp_q.size() == 0);
    ovf_ev   = m_pend && was_full && !popped;
    if (popped) void'(exp_q.pop_front());
    if (m_pend && !ovf_ev) exp_q.push_back(m_pend_w);
    m_ovf  = ovf_ev ? 1'b1 : (cl ? 1'b0 : m_ovf);
    m_udf  = udf_ev ? 1'b1 : (cl ? 1'b0 : m_udf);
    m_pend = 0;
    if (!en) begin
      m_half = 0;
    end else if (v) begin
      if (!m_half) begin
        m_hold = d;
        m_half = 1;
      end else begin
        m_pend   = 1;
        m_pend_w = {d, m_hold};
        m_half   = 0;
      end
    end
  endtask

  task automatic step(input bit v, input logic [AW-1:0] d, input bit rq, input bit cl);
    in_valid = v; in_data = d; rd_req = rq; clr = cl;
    @(posedge clk);
    model_edge(v, d, rq, cl, init);
    #1;
    in_valid = 1'b0; rd_req = 1'b0; clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; init = 1'b0; in_valid = 1'b0; in_data = '0; rd_req = 1'b0; clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (level !== '0) begin bad++; $display("FAIL reset_level: got %0d want 0", level); end
    total++; if (rd_data !== '0) begin bad++; $display("FAIL reset_data: got %h want 0", rd_data); end
    total++; if (pack_half !== 1'b0) begin bad++; $display("FAIL reset_half: got %b want 0", pack_half); end
    total++; if (ovf !== 1'b0 || udf !== 1'b0) begin bad++; $display("FAIL reset_sticky: got %b%b want 00", ovf, udf); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_single_pair();
    init = 1'b1;
    step(1, 16'h1111, 0, 0);
    total++; if (pack_half !== 1'b1) begin bad++; $display("FAIL pair_half_set: got %b want 1", pack_half); end
    step(1, 16'h2222, 0, 0);
    total++; if (pack_half !== 1'b0 || level !== '0) begin bad++; $display("FAIL pair_pending: got half=%b lvl=%0d want half=0 lvl=0", pack_half, level); end
    step(0, '0, 0, 0);
    total++; if (level !== LW'(1)) begin bad++; $display("FAIL pair_level: got %0d want 1", level); end
    total++; if (rd_data !== 32'h22221111) begin bad++; $display("FAIL pair_data: got %h want 22221111", rd_data); end
  endtask

  task automatic test_burst();
    for (int n = 0; n < 300 && exp_q.size() > 0; n++) step(0, '0, 1, 0);
    for (int i = 0; i < 18; i++) step(1, AW'(i), 0, 0);
    step(0, '0, 0, 0);
    total++; if (level !== LW'(9)) begin bad++; $display("FAIL burst_level: got %0d want 9", level); end
    for (int i = 0; i < 9; i++) begin
      logic [DW-1:0] want;
      want = {AW'(2 * i + 1), AW'(2 * i)};
      total++; if (rd_data !== want) begin bad++; $display("FAIL burst_data%0d: got %h want %h", i, rd_data, want); end
      total++; if (level !== LW'(9 - i)) begin bad++; $display("FAIL burst_lvl%0d: got %0d want %0d", i, level, 9 - i); end
      step(0, '0, 1, 0);
    end
    total++; if (level !== '0) begin bad++; $display("FAIL burst_drained: got %0d want 0", level); end
    total++; if (udf !== 1'b0) begin bad++; $display("FAIL burst_udf: got %b want 0", udf); end
  endtask

  task automatic test_full_ovf();
    logic [AW-1:0] lo, hi;
    logic [DW-1:0] first_word;
    lo = AW'($urandom); hi = AW'($urandom);
    first_word = {hi, lo};
    step(1, lo, 0, 0);
    step(1, hi, 0, 0);
    for (int i = 2; i < 2 * DEPTH; i++) step(1, AW'($urandom), 0, 0);
    step(0, '0, 0, 0);
    total++; if (level !== LW'(DEPTH)) begin bad++; $display("FAIL full_level: got %0d want %0d", level, DEPTH); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL full_no_ovf: got %b want 0", ovf); end
    step(1, AW'($urandom), 0, 0);
    step(1, AW'($urandom), 0, 0);
    step(0, '0, 0, 0);
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", ovf); end
    total++; if (level !== LW'(DEPTH)) begin bad++; $display("FAIL ovf_level: got %0d want %0d", level, DEPTH); end
    total++; if (rd_data !== first_word) begin bad++; $display("FAIL ovf_head: got %h want %h", rd_data, first_word); end
    step(0, '0, 0, 1);
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", ovf); end
    step(1, AW'($urandom), 0, 0);
    step(1, AW'($urandom), 0, 0);
    step(0, '0, 1, 0);
    total++; if (level !== LW'(DEPTH)) begin bad++; $display("FAIL full_pushpop_level: got %0d want %0d", level, DEPTH); end
    total++; if (ovf !== m_ovf) begin bad++; $display("FAIL full_pushpop_ovf: got %b want %b", ovf, m_ovf); end
    total++; if (rd_data !== exp_head()) begin bad++; $display("FAIL full_pushpop_head: got %h want %h", rd_data, exp_head()); end
  endtask

  task automatic test_underflow();
    for (int n = 0; n < 300 && exp_q.size() > 0; n++) begin
      total++; if (rd_data !== exp_head()) begin bad++; $display("FAIL drain_data%0d: got %h want %h", n, rd_data, exp_head()); end
      step(0, '0, 1, 0);
    end
    total++; if (level !== '0 || udf !== 1'b0) begin bad++; $display("FAIL drain_end: got lvl=%0d udf=%b want lvl=0 udf=0", level, udf); end
    step(0, '0, 1, 0);
    total++; if (udf !== 1'b1 || level !== '0) begin bad++; $display("FAIL udf_set: got udf=%b lvl=%0d want udf=1 lvl=0", udf, level); end
    step(0, '0, 0, 1);
    total++; if (udf !== 1'b0) begin bad++; $display("FAIL udf_clear: got %b want 0", udf); end
    step(0, '0, 1, 1);
    total++; if (udf !== 1'b1) begin bad++; $display("FAIL udf_set_beats_clr: got %b want 1", udf); end
    step(0, '0, 0, 1);
    step(1, 16'h0a0a, 0, 0);
    step(1, 16'hb0b0, 0, 0);
    step(0, '0, 0, 0);
    total++; if (level !== LW'(1) || rd_data !== 32'hb0b00a0a) begin bad++; $display("FAIL udf_ptrs: got lvl=%0d data=%h want lvl=1 data=b0b00a0a", level, rd_data); end
    step(0, '0, 1, 0);
  endtask

  task automatic test_init_gate();
    init = 1'b0;
    for (int i = 0; i < 4; i++) step(1, AW'($urandom), 0, 0);
    step(0, '0, 0, 0);
    step(0, '0, 0, 0);
    total++; if (level !== '0 || pack_half !== 1'b0) begin bad++; $display("FAIL init_ignore: got lvl=%0d half=%b want 0 0", level, pack_half); end
    init = 1'b1;
    step(1, 16'haaaa, 0, 0);
    total++; if (pack_half !== 1'b1) begin bad++; $display("FAIL init_half: got %b want 1", pack_half); end
    init = 1'b0;
    step(0, '0, 0, 0);
    total++; if (pack_half !== 1'b0) begin bad++; $display("FAIL init_drop_half: got %b want 0", pack_half); end
    init = 1'b1;
    step(1, 16'h1234, 0, 0);
    step(1, 16'h5678, 0, 0);
    step(0, '0, 0, 0);
    total++; if (level !== LW'(1) || rd_data !== 32'h56781234) begin bad++; $display("FAIL init_repack: got lvl=%0d data=%h want lvl=1 data=56781234", level, rd_data); end
    step(0, '0, 1, 0);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 75; i++) step(1, AW'($urandom), 0, 0);
    total++; if (level !== LW'(37) || pack_half !== 1'b1) begin bad++; $display("FAIL pre_reset: got lvl=%0d half=%b want lvl=37 half=1", level, pack_half); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (level !== '0 || pack_half !== 1'b0) begin bad++; $display("FAIL async_reset: got lvl=%0d half=%b want 0 0", level, pack_half); end
    total++; if (rd_data !== '0) begin bad++; $display("FAIL async_reset_data: got %h want 0", rd_data); end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(0, '0, 0, 0);
    step(0, '0, 0, 0);
    total++; if (level !== '0) begin bad++; $display("FAIL post_reset_level: got %0d want 0", level); end
  endtask

  task automatic test_wrap();
    int sent;
    int cyc;
    bit v, rq;
    sent = 0;
    cyc  = 0;
    while ((sent < 1200 || exp_q.size() > 0 || m_pend) && cyc < 20000) begin
      v  = (sent < 1200) && ($urandom_range(0, 3) != 0);
      rq = ($urandom_range(0, 1) == 1);
      step(v, AW'($urandom), rq, 0);
      if (v) sent++;
      cyc++;
      total++; if (level !== exp_level()) begin bad++; $display("FAIL wrap_level c%0d: got %0d want %0d", cyc, level, exp_level()); end
      if (exp_q.size() > 0) begin
        total++; if (rd_data !== exp_head()) begin bad++; $display("FAIL wrap_data c%0d: got %h want %h", cyc, rd_data, exp_head()); end
      end
      total++; if (ovf !== m_ovf || pack_half !== m_half) begin bad++; $display("FAIL wrap_flags c%0d: got ovf=%b half=%b want ovf=%b half=%b", cyc, ovf, pack_half, m_ovf, m_half); end
    end
    total++; if (cyc >= 20000) begin bad++; $display("FAIL wrap_timeout: got %0d cycles want fewer than 20000", cyc); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_pair();
    test_burst();
    test_full_ovf();
    test_underflow();
    test_init_gate();
    test_async_reset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/audio_wr_pack_fifo.md
Name: audio_wr_pack_fifo

Overview:
- Upstream feeder of the DDR3 AXI write master.
- Packs pairs of 16-bit audio samples into 32-bit DDR words and buffers them in a 256-deep first-word-fall-through FIFO.
- Reports the FIFO occupancy as `wfifo_rd_water_level`, which the master uses to decide when to start a burst.
- Pops one word per `wfifo_rd_req` while the master's write-data channel is accepting beats.

Parameters:
- AUDIO_WIDTH, 16, input sample width; must be DQ_WIDTH/2.
- DQ_WIDTH, 32, packed word width presented to the write-data channel.
- FIFO_DEPTH, 256, words of storage; power of two.
- LEVEL_WIDTH, 9, width of the level output; must satisfy 2^LEVEL_WIDTH > FIFO_DEPTH.

Ports:
- M_AXI_ACLK  input  1  single clock for all logic.
- M_AXI_ARESET  input  1  asynchronous, active-high reset.
- DDR_INIT_DONE  input  1  DDR calibrated; samples are discarded while low.
- audio_in_valid  input  1  one-cycle strobe, one sample per strobe; no backpressure.
- audio_in_data  input  AUDIO_WIDTH  sample value.
- wfifo_rd_req  input  1  pop head word this cycle.
- wfifo_rd_data  output  DQ_WIDTH  head word (FWFT); valid whenever level>0.
- wfifo_rd_water_level  output  LEVEL_WIDTH  words currently readable, 0..FIFO_DEPTH.
- pack_half  output  1  1 = a low-half sample is held waiting for its partner.
- ovf_sticky  output  1  a packed word was dropped because the FIFO was full.
- udf_sticky  output  1  `wfifo_rd_req` was asserted while level==0.
- sticky_clr  input  1  synchronous clear of both sticky flags.

Behaviour:
- Reset (async assert, sync release): all outputs 0; write/read pointers 0; hold register 0; `pack_half`=0.
- Clock and reset naming is fixed: one clock, `M_AXI_ACLK`; reset `M_AXI_ARESET`, asynchronous and active-high.
- Reset mid-operation: FIFO contents discarded and pack state cleared immediately; no partial word survives.
- Packer, 2-state machine (LOW, HIGH):
  - LOW + valid: latch sample into hold[15:0]; go HIGH; `pack_half`=1.
  - HIGH + valid: form word {sample, hold[15:0]}, i.e. first sample in bits [15:0]; issue a push; go LOW.
  - No valid: state holds.
- `DDR_INIT_DONE` low: valid strobes ignored and the packer forced to LOW; a held half-word is discarded when `DDR_INIT_DONE` falls.
- Push latency:
  - Word is written one cycle after the second sample strobe.
  - `wfifo_rd_level` increments and `wfifo_rd_data` shows the word (if it is the head) on the following cycle.
  - Total: 2 cycles from second `audio_in_valid` to visible.
- Pop: when `wfifo_rd_req`=1 and level>0, the head advances; the next word appears on `wfifo_rd_data` the next cycle; level decrements the next cycle.
- Underflow: pop with level==0 is ignored (pointers unchanged) and sets `udf_sticky`.
- Full (level==FIFO_DEPTH) with a push and no pop: word dropped, `ovf_sticky` set, pointers unchanged.
- Full with push and pop in the same cycle: both proceed; level stays FIFO_DEPTH; no overflow.
- Simultaneous push and pop at any other level: level unchanged.
- Pointers: log2(FIFO_DEPTH) bits, wrap modulo depth.
- Level: `wr_cnt - rd_cnt` computed on LEVEL_WIDTH-bit counters; never exceeds FIFO_DEPTH.
- `sticky_clr` has priority below a same-cycle set event: the flag stays 1.
- Packing order is bit-exact: the DDR word at address N holds samples 2N (low half) and 2N+1 (high half).

Test Plan:
- Reset then `DDR_INIT_DONE`=1; strobe samples 0x1111, 0x2222 -> after 2 cycles level=1, `wfifo_rd_data`=0x22221111, `pack_half` back to 0.
- Strobe 18 samples 0x0000..0x0011; pop 9 consecutive cycles (one burst) -> rd_data sequence 0x00010000, 0x00030002 … 0x00110010; level 9→0; `udf_sticky`=0.
- Fill to 256 words, push one more word with no pop -> level stays 256, `ovf_sticky`=1, head word unchanged; then push + pop same cycle -> level 256, `ovf_sticky` unchanged.
- `wfifo_rd_req`=1 at level 0 -> `udf_sticky`=1, pointers unchanged; `sticky_clr` pulse -> flag 0 next cycle.
- `DDR_INIT_DONE`=0 with 4 sample strobes -> level 0, `pack_half` 0; one sample, then `DDR_INIT_DONE` drops -> held half discarded; next pair packs correctly.
- Assert `M_AXI_ARESET` asynchronously mid-stream at level 37 with `pack_half`=1 -> level and `pack_half` 0 without a clock edge; wrap test of 600 words streamed and popped with no mismatches.
